// File: rtl/rtc_bus_engine.sv
// Burst engine for a multiplexed-bus RTC: address phase, data phase and gap per access.
// Optional RTC_CMD_TRAILER_EN appends a cmd_code write to 8'hF0 after each write burst.
module rtc_bus_engine #(
  parameter int                 DATA_W   = 8,
  parameter int                 NUM_REGS = 9,
  parameter int                 IDX_W    = 4,
  parameter logic [DATA_W-1:0]  ADDR_OFS = 8'h21,
  parameter int                 T_SU     = 2,
  parameter int                 T_PW     = 4,
  parameter int                 T_HD     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rw,
  input  logic [IDX_W-1:0]  base_idx,
  input  logic [IDX_W:0]    count,
  input  logic [DATA_W-1:0] cmd_code,
  output logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic              AD,
  output logic              CS,
  output logic              RD,
  output logic              WR,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  input  logic [DATA_W-1:0] bus_in
);

  typedef enum logic [3:0] {
    IDLE, A_SU, A_PW, A_HD, D_SU, D_PW, D_HD, GAP, DONE
  } state_t;

  localparam logic [7:0]      SU_LAST  = 8'(T_SU - 1);
  localparam logic [7:0]      PW_LAST  = 8'(T_PW - 1);
  localparam logic [7:0]      HD_LAST  = 8'(T_HD - 1);
  localparam logic [IDX_W:0]  MAX_CNT  = (IDX_W+1)'(NUM_REGS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
  localparam logic [DATA_W-1:0] TRAIL_ADDR = DATA_W'(8'hF0);

  state_t              state, state_nxt;
  logic [7:0]          cnt;
  logic                last;
  logic [IDX_W-1:0]    idx, idx_inc;
  logic [IDX_W:0]      remain;
  logic                rw_q;
  logic                trail_q;
  logic                trail_start;
  logic [DATA_W-1:0]   cmd_q;
  logic [DATA_W-1:0]   wdata_q;

  assign idx_inc = (idx >= LAST_IDX) ? '0 : idx + 1'b1;

  // Phase-end detection and next-state selection
  always_comb begin
    last        = 1'b1;
    state_nxt   = state;
    trail_start = 1'b0;
`ifdef RTC_CMD_TRAILER_EN
    trail_start = (state == GAP) && rw_q && !trail_q && (remain <= (IDX_W+1)'(1));
`endif
    case (state)
      A_SU, D_SU: last = (cnt == SU_LAST);
      A_PW, D_PW: last = (cnt == PW_LAST);
      A_HD, D_HD: last = (cnt == HD_LAST);
      default:    last = 1'b1;
    endcase
    case (state)
      IDLE: if (start) state_nxt = (count == '0) ? DONE : A_SU;
      A_SU: if (last) state_nxt = A_PW;
      A_PW: if (last) state_nxt = A_HD;
      A_HD: if (last) state_nxt = D_SU;
      D_SU: if (last) state_nxt = D_PW;
      D_PW: if (last) state_nxt = D_HD;
      D_HD: if (last) state_nxt = GAP;
      GAP: begin
        if (trail_q)                                    state_nxt = DONE;
        else if (remain > (IDX_W+1)'(1) || trail_start) state_nxt = A_SU;
        else                                            state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      remain   <= '0;
      rw_q     <= 1'b0;
      trail_q  <= 1'b0;
      cmd_q    <= '0;
      wdata_q  <= '0;
      wr_idx   <= '0;
      rd_data  <= '0;
      rd_idx   <= '0;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      rd_valid <= 1'b0;
      if (state_nxt != state) cnt <= '0;
      else if (busy)          cnt <= cnt + 8'd1;
      case (state)
        IDLE: if (start) begin
          rw_q    <= rw;
          cmd_q   <= cmd_code;
          idx     <= base_idx;
          wr_idx  <= base_idx;
          trail_q <= 1'b0;
          remain  <= (count > MAX_CNT) ? MAX_CNT : count;
        end
        A_HD: if (last && rw_q && !trail_q) wdata_q <= wr_data;
        D_PW: if (last && !rw_q) begin
          rd_data  <= bus_in;
          rd_idx   <= idx;
          rd_valid <= 1'b1;
        end
        GAP: if (!trail_q) begin
          // The trailer keeps wr_idx on the last real slot
          idx    <= idx_inc;
          remain <= remain - 1'b1;
          if (trail_start)                   trail_q <= 1'b1;
          else if (remain > (IDX_W+1)'(1))   wr_idx  <= idx_inc;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE) && (state != DONE);
  assign done = (state == DONE);

  // Bus pins are decoded straight from state so reset releases them immediately
  always_comb begin
    CS      = 1'b1;
    AD      = 1'b1;
    RD      = 1'b1;
    WR      = 1'b1;
    bus_oe  = 1'b0;
    bus_out = '0;
    case (state)
      A_SU, A_PW, A_HD: begin
        CS      = 1'b0;
        AD      = 1'b0;
        bus_oe  = 1'b1;
        bus_out = trail_q ? TRAIL_ADDR : ADDR_OFS + DATA_W'(idx);
        WR      = (state != A_PW);
      end
      D_SU, D_PW, D_HD: begin
        CS = 1'b0;
        AD = 1'b1;
        if (rw_q) begin
          bus_oe  = 1'b1;
          bus_out = trail_q ? cmd_q : wdata_q;
          WR      = (state != D_PW);
        end else begin
          RD = (state != D_PW);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rtc_bus_engine.sv
// Scoreboard bench for rtc_bus_engine: expected bus events are queued at stimulus time
// and matched against strobes, rd_valid and done observed on the falling edge.
module tb_rtc_bus_engine;

  localparam int T_PW = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, rw;
  logic [3:0] base_idx;
  logic [4:0] count;
  logic [7:0] cmd_code;
  logic [3:0] wr_idx;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic [3:0] rd_idx;
  logic       rd_valid, busy, done;
  logic       AD, CS, RD, WR;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic [7:0] bus_in;

  rtc_bus_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rw(rw), .base_idx(base_idx),
    .count(count), .cmd_code(cmd_code), .wr_idx(wr_idx), .wr_data(wr_data),
    .rd_data(rd_data), .rd_idx(rd_idx), .rd_valid(rd_valid), .busy(busy),
    .done(done), .AD(AD), .CS(CS), .RD(RD), .WR(WR), .bus_out(bus_out),
    .bus_oe(bus_oe), .bus_in(bus_in)
  );

  always #5 clk = ~clk;

  int cmpCnt = 0;
  int errCnt = 0;
  int cyc = 0;
  int startCyc = 0;
  int doneCnt = 0;
  logic [19:0] expQ[$];
  logic [7:0] wmem[16];
  logic [7:0] rmem[16];
  logic [3:0] rdSlot = '0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) wr_data <= wmem[wr_idx];
  assign bus_in = rmem[rdSlot];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmpCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic popCheck(input string tag, input logic [3:0] kind, input logic [15:0] val);
    logic [19:0] e;
    if (expQ.size() == 0) e = 20'hFFFFF;
    else e = expQ.pop_front();
    checkOutput(tag, {12'h0, kind, val}, {12'h0, e});
  endtask

  // Bus monitor: strobe edges produce scoreboard events, widths checked on release
  int wrLen = 0, rdLen = 0;
  logic prevWr = 1'b1, prevRd = 1'b1;
  always @(negedge clk) begin
    if (!rst_n) begin
      wrLen = 0; rdLen = 0; prevWr = 1'b1; prevRd = 1'b1;
    end else begin
      if (!WR || !RD) checkOutput("strobe_rules", {30'h0, ~WR & ~RD, CS}, 32'h0);
      if (!WR) begin
        if (prevWr) begin
          checkOutput("wr_oe", {31'h0, bus_oe}, 32'h1);
          if (!AD) begin
            popCheck("addr", 4'd1, {8'h0, bus_out});
            rdSlot = (bus_out >= 8'h21 && bus_out < 8'h2A) ? 4'(bus_out - 8'h21) : 4'hF;
          end else begin
            popCheck("wdata", 4'd2, {8'h0, bus_out});
          end
        end
        wrLen++;
      end else if (!prevWr) begin
        checkOutput("wr_width", wrLen, T_PW);
        wrLen = 0;
      end
      if (!RD) begin
        if (prevRd) checkOutput("rd_phase", {30'h0, bus_oe, AD}, 32'h1);
        rdLen++;
      end else if (!prevRd) begin
        checkOutput("rd_width", rdLen, T_PW);
        rdLen = 0;
      end
      if (rd_valid) popCheck("rdata", 4'd3, {4'h0, rd_idx, rd_data});
      if (done) begin
        popCheck("done_lat", 4'd4, 16'(cyc - startCyc + 1));
        doneCnt++;
      end
      prevWr = WR;
      prevRd = RD;
    end
  end

  task automatic applyStimulus(input logic r, input logic [3:0] b, input logic [4:0] c,
                               input logic [7:0] cmd, input bit spam);
    int n, slot, acc;
    n = (c > 5'd9) ? 9 : int'(c);
    slot = int'(b);
    acc = n;
    for (int i = 0; i < n; i++) begin
      expQ.push_back({4'd1, 8'h0, 8'(8'h21 + slot)});
      if (r) expQ.push_back({4'd2, 8'h0, wmem[slot]});
      else   expQ.push_back({4'd3, 4'h0, 4'(slot), rmem[slot]});
      slot = (slot + 1) % 9;
    end
`ifdef RTC_CMD_TRAILER_EN
    if (r && n > 0) begin
      expQ.push_back({4'd1, 8'h0, 8'hF0});
      expQ.push_back({4'd2, 8'h0, cmd});
      acc++;
    end
`endif
    expQ.push_back({4'd4, 16'(acc * 17 + 1)});
    @(negedge clk);
    start = 1'b1; rw = r; base_idx = b; count = c; cmd_code = cmd;
    @(posedge clk);
    #1 startCyc = cyc;
    if (!spam) start = 1'b0;
    else begin
      for (int k = 0; k < 400 && busy; k++) begin
        @(negedge clk);
        if (busy) begin
          rw = $urandom_range(0, 1); base_idx = 4'($urandom_range(0, 8));
          count = 5'($urandom_range(1, 9)); cmd_code = 8'($urandom);
        end
      end
      start = 1'b0;
    end
  endtask

  task automatic waitDone(input int target);
    int k;
    for (k = 0; k < 2000 && doneCnt < target; k++) @(negedge clk);
    if (doneCnt < target) checkOutput("timeout", 32'h1, 32'h0);
    @(negedge clk);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ctl"}, {24'h0, CS, AD, RD, WR, bus_oe, busy, done, rd_valid}, 32'hF0);
    checkOutput({tag, "_bus"}, {24'h0, bus_out}, 32'h0);
    checkOutput({tag, "_rd"}, {20'h0, rd_idx, rd_data}, 32'h0);
    checkOutput({tag, "_widx"}, {28'h0, wr_idx}, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      wmem[i] = 8'(8'h60 + i * 7);
      rmem[i] = 8'(8'h30 + i * 3);
    end
    wmem[0] = 8'h45;
    rmem[3] = 8'h12; rmem[4] = 8'h05; rmem[5] = 8'h16;
    start = 0; rw = 0; base_idx = 0; count = 0; cmd_code = 8'hF1;
    rst_n = 1'b0;
    #2 checkResetState("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] write base 0 count 1");
    applyStimulus(1'b1, 4'd0, 5'd1, 8'hF1, 1'b0);
    waitDone(1);

    $display("[TB] read base 3 count 3");
    applyStimulus(1'b0, 4'd3, 5'd3, 8'hF1, 1'b0);
    waitDone(2);

    $display("[TB] read base 7 count 4 wrap");
    applyStimulus(1'b0, 4'd7, 5'd4, 8'hF1, 1'b0);
    waitDone(3);

    $display("[TB] count 0");
    applyStimulus(1'b1, 4'd2, 5'd0, 8'hF1, 1'b0);
    waitDone(4);
    checkOutput("cnt0_cs", {31'h0, CS}, 32'h1);

    $display("[TB] read count 12 clamps to 9");
    applyStimulus(1'b0, 4'd5, 5'd12, 8'hF1, 1'b0);
    waitDone(5);

    $display("[TB] reset during write data strobe");
    applyStimulus(1'b1, 4'd1, 5'd2, 8'hF1, 1'b0);
    for (int k = 0; k < 100 && !(!WR && AD); k++) @(negedge clk);
    checkOutput("reach_dpw", {30'h0, WR, AD}, 32'h1);
    #1 rst_n = 1'b0;
    #1 checkOutput("async_rst", {28'h0, CS, WR, bus_oe, busy}, 32'hC);
    checkResetState("mid_reset");
    expQ.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("no_resume", {30'h0, CS, busy}, 32'h2);

    $display("[TB] restart after reset");
    applyStimulus(1'b1, 4'd8, 5'd2, 8'hF1, 1'b0);
    waitDone(6);

    $display("[TB] start spammed during write burst");
    applyStimulus(1'b1, 4'd2, 5'd3, 8'hF1, 1'b1);
    waitDone(7);
    repeat (40) @(negedge clk);
    checkOutput("spam_idle", {31'h0, busy}, 32'h0);
    checkOutput("spam_done_cnt", doneCnt, 7);
    checkOutput("queue_empty", expQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
    $finish;
  end

endmodule

// File: doc/rtc_bus_engine.md
RTC_BUS_ENGINE -- requirements
Module: rtc_bus_engine

Interface
REQ-001 The block SHALL use these parameters (name, default, meaning):
- DATA_W, 8, bus and register width.
- NUM_REGS, 9, register slots: seconds, minutes, hours, day, month, year, timer s/m/h.
- IDX_W, 4, slot index width.
- ADDR_OFS, 8'h21, RTC address of slot 0; slot i maps to ADDR_OFS+i.
- T_SU, 2, setup cycles, >=1.
- T_PW, 4, strobe low cycles, >=1.
- T_HD, 2, hold cycles, >=1.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- Clock, in, 1, single clock.
- Reset, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle request; accepted only in IDLE.
- rw, in, 1, 1 = write burst, 0 = read burst.
- base_idx, in, IDX_W, first slot.
- count, in, IDX_W+1, number of accesses.
- cmd_code, in, DATA_W, transfer command byte.
- wr_idx, out, IDX_W, slot whose write data is required.
- wr_data, in, DATA_W, data for wr_idx, valid one cycle after wr_idx changes.
- rd_data, out, DATA_W, captured read byte.
- rd_idx, out, IDX_W, slot of rd_data.
- rd_valid, out, 1, one-cycle strobe.
- busy, out, 1, transaction in progress.
- done, out, 1, one-cycle completion strobe.
- AD, out, 1, 0 = address phase, 1 = data phase.
- CS, out, 1, chip select, active low.
- RD, out, 1, read strobe, active low.
- WR, out, 1, write strobe, active low.
- bus_out, out, DATA_W, bus drive value.
- bus_oe, out, 1, bus drive enable.
- bus_in, in, DATA_W, sampled bus.

Function
REQ-003 States SHALL be: IDLE, A_SU, A_PW, A_HD, D_SU, D_PW, D_HD, GAP, DONE.
REQ-004 When start=1 in IDLE, the block SHALL latch rw, base_idx, count and cmd_code, and assert busy from the next cycle.
REQ-005 When count=0, the block SHALL go IDLE->DONE, pulse done once, and produce no bus activity.
REQ-006 In A_SU/A_PW/A_HD the block SHALL drive CS=0, AD=0, bus_oe=1, bus_out=ADDR_OFS+idx.
REQ-007 WR SHALL be 0 only in A_PW.
REQ-008 A_SU, A_PW and A_HD SHALL last T_SU, T_PW and T_HD cycles respectively.
REQ-009 In D_SU/D_PW/D_HD the block SHALL drive CS=0 and AD=1, with phase lengths of T_SU, T_PW and T_HD cycles.
REQ-010 On a write, wr_idx SHALL equal the current idx during A_SU.
REQ-011 On a write, wr_data SHALL be registered on entry to D_SU, with bus_oe=1, bus_out set to that register, and WR=0 only in D_PW.
REQ-012 On a read, bus_oe SHALL be 0 throughout D_*, with RD=0 only in D_PW.
REQ-013 On a read, bus_in SHALL be sampled on the last D_PW cycle; rd_data/rd_idx update and rd_valid pulses on the following cycle.
REQ-014 GAP SHALL last 1 cycle with CS=AD=RD=WR=1 and bus_oe=0.
REQ-015 After GAP, idx SHALL become (idx+1) mod NUM_REGS; the block then enters A_SU, or DONE after the last access.
REQ-016 Each access SHALL take 2*(T_SU+T_PW+T_HD)+1 cycles.
REQ-017 base_idx+count exceeding NUM_REGS SHALL wrap the index to 0.
REQ-018 count>NUM_REGS SHALL be clamped to NUM_REGS.
REQ-019 DONE SHALL last 1 cycle with done=1 and busy=0, then return to IDLE; start in DONE is ignored.
REQ-020 start while busy SHALL be ignored with no effect on latched inputs.
REQ-021 RD and WR SHALL never be low in the same cycle, and RD/WR SHALL never be low while CS=1.

Reset
REQ-022 Reset=0 SHALL asynchronously force IDLE with CS=AD=RD=WR=1, bus_oe=0, bus_out=0, busy=done=rd_valid=0, rd_data=0, rd_idx=0, wr_idx=0, including mid-transaction.
REQ-023 Release of Reset SHALL take effect on the next Clock edge, and no transaction SHALL resume.

Configuration
REQ-024 Macro RTC_CMD_TRAILER_EN SHALL control an extra trailer access.
- Defined: after the last write-burst access, one extra write access of cmd_code to address 8'hF0 is made before DONE; read bursts are unaffected; wr_idx is held.
- Undefined: no trailer access; cmd_code is unused.

Verification
REQ-025 Bench SHALL cover these directed scenarios (defaults):
- Write, base 0, count 1, wr_data=8'h45: bus shows 8'h21 with WR low 4 cycles, then 8'h45 with WR low 4 cycles; done at 18 cycles after start (17-cycle access + DONE).
- Read, base 3, count 3, bus_in model returns 8'h12/8'h05/8'h16: rd_valid 3 times with rd_idx 3/4/5 and matching data; RD never overlaps WR.
- Read, base 7, count 4: addresses 8'h28, 8'h29, 8'h21, 8'h22 (wrap); count=0 gives done after 1 cycle with CS stuck at 1.
- Reset low during D_PW of a write: CS/WR go 1 and bus_oe goes 0 in the same cycle; after release the block is idle; a new start completes normally.
- start pulsed every cycle during a burst: no restart and a single done; with RTC_CMD_TRAILER_EN and cmd_code=8'hF1, the final access is address 8'hF0 then data 8'hF1.
